fifo_stream_reader: RTL

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_reader_pkg.sv | 15 +
 rtl/fifo_reader_skid.sv | 65 ++++++
 rtl/fifo_stream_reader.sv | 63 ++++++
 3 files changed

// File: rtl/fifo_reader_pkg.sv
// Shared constants for the FIFO stream reader: buffer depth, occupancy width,
// statistics counter width and the modulo-3 pointer increment.
package fifo_reader_pkg;

    localparam int BUF_DEPTH   = 3;
    localparam int OCC_W       = 2;
    localparam int POP_COUNT_W = 32;

    typedef logic [OCC_W-1:0] occ_t;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// Three-entry in-order buffer with a registered head word. The caller never
// pushes into a full buffer unless it pops in the same cycle.
module fifo_reader_skid
    import fifo_reader_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [OCC_W-1:0] occ
);

    logic [WIDTH-1:0] mem [BUF_DEPTH];
    logic [1:0]       rd_ptr;
    logic [1:0]       wr_ptr;
    logic             do_pop;
    logic             do_push;
    logic [WIDTH-1:0] dout_nxt;

    assign do_pop  = pop && (occ != '0);
    assign do_push = push && ((occ != OCC_W'(BUF_DEPTH)) || do_pop);

    // Head word is precomputed so dout comes straight from a flop.
    always_comb begin
        dout_nxt = dout;
        if (do_pop) begin
            if (occ == OCC_W'(1))
                dout_nxt = do_push ? din : dout;
            else
                dout_nxt = mem[ptr_inc(rd_ptr)];
        end else if ((occ == '0) && do_push) begin
            dout_nxt = din;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            occ    <= '0;
            dout   <= '0;
        end else begin
            dout <= dout_nxt;
            if (do_push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a read-latency-1 FIFO into a valid/ready stream via a 3-entry buffer.
// Optional accepted-word counter pop_count is enabled by FIFO_READER_STAT_EN.
module fifo_stream_reader
    import fifo_reader_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fifo_empty,
    output logic                   fifo_re,
    input  logic [WIDTH-1:0]       fifo_dout,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [WIDTH-1:0]       m_data
`ifdef FIFO_READER_STAT_EN
    ,
    output logic [POP_COUNT_W-1:0] pop_count
`endif
);

    // Handshake: a word moves when m_valid && m_ready on a rising edge; m_valid
    // never waits on m_ready, and m_data holds steady while m_valid && !m_ready.
    logic       infl;
    occ_t       occ;
    logic [2:0] pending;
    logic       xfer;

    // Reads are credited against buffer slots only, so m_ready never reaches fifo_re.
    assign pending = {1'b0, occ} + {2'b00, infl};
    assign fifo_re = !reset && !fifo_empty && (pending < 3'(BUF_DEPTH));
    assign m_valid = (occ != '0);
    assign xfer    = m_valid && m_ready;

    always_ff @(posedge clk) begin
        if (reset)
            infl <= 1'b0;
        else
            infl <= fifo_re;
    end

    fifo_reader_skid #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk  (clk),
        .reset(reset),
        .push (infl),
        .din  (fifo_dout),
        .pop  (xfer),
        .dout (m_data),
        .occ  (occ)
    );

`ifdef FIFO_READER_STAT_EN
    always_ff @(posedge clk) begin
        if (reset)
            pop_count <= '0;
        else if (xfer)
            pop_count <= pop_count + POP_COUNT_W'(1);
    end
`endif

endmodule
